// File: rtl/mem_req_queue_pkg.sv
//==============================================================================
// Module   : mem_req_queue_pkg
// Purpose  : Shared types and constants for the MAU-to-data-memory request queue.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package mem_req_queue_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   localparam logic c_RW_LOAD  = 1'b0;
   localparam logic c_RW_STORE = 1'b1;

   localparam int c_ROW_W   = 6;
   localparam int c_BANK_W  = 3;
   localparam int c_ADDR_W  = c_ROW_W + c_BANK_W;
   localparam int c_DATA_W  = 32;
   localparam int c_ENTRY_W = 1 + c_ADDR_W + c_DATA_W;

   typedef struct packed {
      logic                rw;
      logic [c_ADDR_W-1:0] addr;
      logic [c_DATA_W-1:0] data;
   } entry_t;

endpackage

`default_nettype wire

// File: rtl/memq_fifo.sv
//==============================================================================
// Module   : memq_fifo
// Purpose  : Parameterised synchronous FIFO, async active-low reset.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module memq_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 42
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_full,
   output logic             o_empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [PTR_W:0]   r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   // A push is refused while full even if a pop frees a slot this same cycle.
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_dout  = r_mem[r_head];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_tail] <= i_din;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_tail <= r_tail + 1'b1;
         if (w_pop)  r_head <= r_head + 1'b1;
         if (w_push & ~w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop & ~w_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/mem_req_queue.sv
//==============================================================================
// Module   : mem_req_queue
// Purpose  : Queues MAU load/store requests and issues them one at a time to
//            the banked data memory. Optional stall counter: MEMQ_STALL_CNT_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_req_queue
   import mem_req_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_in,
   input  logic                rw_in,
   input  logic [c_ADDR_W-1:0] addr_in,
   input  logic [c_DATA_W-1:0] din_in,
   output logic                halt,
   output logic                empty,
   output logic                reqMEM,
   output logic                rwMEM,
   output logic [c_ROW_W-1:0]  addrMEM,
   output logic [c_BANK_W-1:0] bankSelect,
   output logic [c_DATA_W-1:0] doutMEM,
   input  logic                ready,
   input  logic                ackMEM,
   input  logic [c_DATA_W-1:0] dinMEM,
   output logic                ackMAU,
   output logic [c_DATA_W-1:0] doutMAU
`ifdef MEMQ_STALL_CNT_EN
   ,
   output logic [15:0]         stall_cnt
`endif
);

   state_t              r_state;
   state_t              w_state_nxt;
   entry_t              w_head;
   logic                w_fifo_full;
   logic                w_fifo_empty;
   logic                w_pop;
   logic                w_req;
   logic                w_done;
   logic                r_rw;
   logic [c_ROW_W-1:0]  r_row;
   logic [c_BANK_W-1:0] r_bank;
   logic [c_DATA_W-1:0] r_dout;
   logic                r_ack;
   logic [c_DATA_W-1:0] r_dout_mau;

   memq_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (c_ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (req_in),
      .i_din   ({rw_in, addr_in, din_in}),
      .i_pop   (w_pop),
      .o_dout  (w_head),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_req       = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_fifo_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            w_req = ready;
            if (ready) w_state_nxt = WAIT;
         end
         WAIT: begin
            if (ackMEM) begin
               w_done      = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // The issued request is latched at pop time and held until the next pop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rw       <= 1'b0;
         r_row      <= '0;
         r_bank     <= '0;
         r_dout     <= '0;
         r_ack      <= 1'b0;
         r_dout_mau <= '0;
      end else begin
         if (w_pop) begin
            r_rw   <= w_head.rw;
            r_row  <= w_head.addr[c_ADDR_W-1:c_BANK_W];
            r_bank <= w_head.addr[c_BANK_W-1:0];
            r_dout <= w_head.data;
         end
         r_ack <= w_done;
         if (w_done) begin
            r_dout_mau <= (r_rw == c_RW_STORE) ? '0 : dinMEM;
         end
      end
   end

`ifdef MEMQ_STALL_CNT_EN
   logic [15:0] r_stall_cnt;
   logic [1:0]  w_stall_inc;
   logic [16:0] w_stall_sum;

   // Both stall sources can hit in one cycle; each contributes one count.
   assign w_stall_inc = {1'b0, req_in & w_fifo_full}
                      + {1'b0, (r_state == ISSUE) & ~ready};
   assign w_stall_sum = {1'b0, r_stall_cnt} + {15'd0, w_stall_inc};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= '0;
      end else begin
         r_stall_cnt <= w_stall_sum[16] ? 16'hFFFF : w_stall_sum[15:0];
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

   assign halt       = w_fifo_full;
   assign empty      = w_fifo_empty & (r_state == IDLE);
   assign reqMEM     = w_req;
   assign rwMEM      = r_rw;
   assign addrMEM    = r_row;
   assign bankSelect = r_bank;
   assign doutMEM    = r_dout;
   assign ackMAU     = r_ack;
   assign doutMAU    = r_dout_mau;

endmodule

`default_nettype wire

// File: tb/tb_mem_req_queue.sv
//==============================================================================
// Module   : tb_mem_req_queue
// Purpose  : Scoreboard bench for mem_req_queue with a behavioural banked memory.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_req_queue;
   import mem_req_queue_pkg::*;

   localparam int DEPTH = 4;

   typedef struct {
      bit         rw;
      bit [8:0]   addr;
      bit [31:0]  data;
   } req_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_in = 1'b0;
   logic        rw_in = 1'b0;
   logic [8:0]  addr_in = '0;
   logic [31:0] din_in = '0;
   logic        halt, empty, reqMEM, rwMEM, ackMAU;
   logic [5:0]  addrMEM;
   logic [2:0]  bankSelect;
   logic [31:0] doutMEM, doutMAU;
   logic        ready = 1'b0;
   logic        ackMEM = 1'b0;
   logic [31:0] dinMEM = '0;
`ifdef MEMQ_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   int          checks = 0;
   int          errors = 0;
   req_t        issue_q[$];
   logic [31:0] ack_q[$];
   logic [31:0] ref_mem [512];
   logic [31:0] sim_mem [512];

   int          ready_mode = 1;   // 0 random, 1 always ready, 2 never ready
   int          lat = 4;
   bit          env_busy = 0;
   bit          env_real_ack = 0;
   bit          mon_exp_ack = 0;
   int          ack_seen = 0;

   always #5 clk = ~clk;

   mem_req_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .req_in(req_in), .rw_in(rw_in), .addr_in(addr_in),
      .din_in(din_in), .halt(halt), .empty(empty), .reqMEM(reqMEM), .rwMEM(rwMEM),
      .addrMEM(addrMEM), .bankSelect(bankSelect), .doutMEM(doutMEM), .ready(ready),
      .ackMEM(ackMEM), .dinMEM(dinMEM), .ackMAU(ackMAU), .doutMAU(doutMAU)
`ifdef MEMQ_STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: in-order completion, so each response is known at push time.
   task automatic sb_push(input bit rw, input bit [8:0] a, input bit [31:0] d);
      req_t e;
      e.rw = rw; e.addr = a; e.data = d;
      issue_q.push_back(e);
      if (rw) begin
         ref_mem[a] = d;
         ack_q.push_back(32'd0);
      end else begin
         ack_q.push_back(ref_mem[a]);
      end
   endtask

   task automatic send(input bit rw, input bit [8:0] a, input bit [31:0] d);
      bit ok = 0;
      req_in = 1'b1; rw_in = rw; addr_in = a; din_in = d;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clk);
         if (!halt) begin
            ok = 1;
            sb_push(rw, a, d);
         end
         tick();
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL push_timeout: request addr=%0d never accepted", a);
      end
      req_in = 1'b0;
   endtask

   task automatic drain();
      bit ok = 0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(negedge clk);
         if (empty && ack_q.size() == 0 && issue_q.size() == 0 && !ackMAU) ok = 1;
      end
      chk("drain_done", ok, 1'b1);
      tick();
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      reset = 1'b0;
      req_in = 1'b0;
      #1;
      chk("rst_ctrl", {halt, empty, reqMEM, rwMEM, ackMAU}, 5'b01000);
      chk("rst_issue", {addrMEM, bankSelect, doutMEM}, 41'd0);
      chk("rst_doutMAU", doutMAU, 32'd0);
`ifdef MEMQ_STALL_CNT_EN
      chk("rst_stall_cnt", stall_cnt, 16'd0);
`endif
      issue_q.delete();
      ack_q.delete();
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      tick();
   endtask

   // Behavioural banked memory: fixed latency, one access at a time.
   initial begin
      bit          st;
      bit          s_rw;
      bit [8:0]    s_a;
      bit [31:0]   s_d;
      int          cnt;
      forever begin
         @(negedge clk);
         st = reset && reqMEM;
         if (st) begin
            s_rw = rwMEM; s_a = {addrMEM, bankSelect}; s_d = doutMEM;
         end
         tick();
         ackMEM = 1'b0;
         env_real_ack = 0;
         if (!reset) begin
            env_busy = 0;
         end else if (st) begin
            env_busy = 1;
            cnt = lat;
         end else if (env_busy) begin
            cnt--;
            if (cnt == 0) begin
               ackMEM = 1'b1;
               env_real_ack = 1;
               env_busy = 0;
               if (s_rw) begin
                  sim_mem[s_a] = s_d;
                  dinMEM = $urandom;
               end else begin
                  dinMEM = sim_mem[s_a];
               end
            end
         end else if ($urandom_range(0, 7) == 0) begin
            ackMEM = 1'b1;          // stray ack outside WAIT
            dinMEM = $urandom;
         end
         case (ready_mode)
            0:       ready = ($urandom_range(0, 2) != 0);
            1:       ready = 1'b1;
            default: ready = 1'b0;
         endcase
      end
   end

   // Monitor: checks issued requests and acknowledges against the scoreboard.
   initial begin
      req_t        e;
      logic [41:0] act, exp;
      forever begin
         @(negedge clk);
         if (!reset) begin
            mon_exp_ack = 0;
            continue;
         end
         if (reqMEM) begin
            if (issue_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL issue_unexpected: reqMEM with addr=%0d and nothing pending", {addrMEM, bankSelect});
            end else begin
               e = issue_q.pop_front();
               act = {rwMEM, addrMEM, bankSelect, (e.rw ? doutMEM : 32'd0)};
               exp = {e.rw, 6'(e.addr / 9'd8), 3'(e.addr % 9'd8), (e.rw ? e.data : 32'd0)};
               chk("issue_fields", act, exp);
            end
         end
         if (ackMAU || mon_exp_ack) begin
            chk("ack_timing", ackMAU, mon_exp_ack);
            if (ackMAU) begin
               ack_seen++;
               if (ack_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL ack_unexpected: doutMAU=%0h with nothing outstanding", doutMAU);
               end else begin
                  chk("doutMAU", doutMAU, ack_q.pop_front());
               end
            end
         end
         mon_exp_ack = ackMEM && env_real_ack;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [41:0] snap;
      int          acks0;
      for (int i = 0; i < 512; i++) begin
         sim_mem[i] = i * 32'h9E37 + 32'd1;
         ref_mem[i] = i * 32'h9E37 + 32'd1;
      end
      tick();
      do_reset();

      // Single store, ready bank: issue in the cycle after the pop edge.
      ready_mode = 1;
      tick();
      send(1'b1, 9'd10, 32'd7);
      @(negedge clk);
      chk("store_idle_noreq", reqMEM, 1'b0);
      @(negedge clk);
      chk("store_req_latency", reqMEM, 1'b1);
      chk("store_fields", {rwMEM, addrMEM, bankSelect, doutMEM}, {1'b1, 6'd1, 3'd2, 32'd7});
      tick();
      drain();

      // Single load returning 55.
      sim_mem[3] = 32'd55;
      ref_mem[3] = 32'd55;
      send(1'b0, 9'd3, 32'hDEAD);
      drain();

      // Fill the queue against a stalled bank; the sixth request waits.
      ready_mode = 2;
      tick();
      for (int i = 0; i < 5; i++) send(i[0], 9'(40 + i), 32'h100 + i);
      @(negedge clk);
      chk("fill_halt", halt, 1'b1);
      tick();
      fork
         send(1'b1, 9'd45, 32'h105);
         begin
            repeat (4) begin
               @(negedge clk);
               chk("fill_halt_hold", halt, 1'b1);
            end
            ready_mode = 0;
         end
      join
      drain();

      // Bank busy for 6 cycles in ISSUE.
      do_reset();
      ready_mode = 2;
      tick();
      send(1'b0, 9'd77, 32'h1234);
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 0) snap = {rwMEM, addrMEM, bankSelect, doutMEM};
         chk("busy_noreq", reqMEM, 1'b0);
         chk("busy_stable", {rwMEM, addrMEM, bankSelect, doutMEM}, snap);
      end
      ready_mode = 1;
      @(negedge clk);
      chk("busy_release_req", reqMEM, 1'b1);
`ifdef MEMQ_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, 16'd6);
`endif
      tick();
      drain();

      // Reset while a load waits for the memory.
      lat = 8;
      send(1'b0, 9'd5, 32'hCAFE_F00D);
      @(negedge clk);
      @(negedge clk);
      chk("abort_req_seen", reqMEM, 1'b1);
      tick();
      do_reset();
      acks0 = ack_seen;
      repeat (15) @(negedge clk);
      chk("abort_no_ack", ack_seen - acks0, 0);
      tick();

      // Pointer wrap: store then load to addresses 0..9.
      lat = 4;
      ready_mode = 0;
      for (int i = 0; i < 10; i++) begin
         send(1'b1, 9'(i), $urandom);
         send(1'b0, 9'(i), $urandom);
      end
      drain();
      @(negedge clk);
      chk("wrap_empty", empty, 1'b1);
      tick();

      // Randomised traffic with varying latency, gaps and bank readiness.
      for (int i = 0; i < 80; i++) begin
         lat = $urandom_range(1, 4);
         ready_mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
         send($urandom_range(0, 1) == 1,
              ($urandom_range(0, 5) == 0) ? 9'($urandom) : 9'($urandom_range(0, 15)),
              $urandom);
         repeat ($urandom_range(0, 3)) tick();
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
